// File: rtl/aes_pkg.sv
// AES-128 shared constants and GF(2^8) helpers.
// S-box, inverse S-box, Rcon, FSM state type, xtime, gmul.
package aes_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Index 0 and 11..15 are padding so a 4-bit index never leaves the table.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04,
        8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round, shared by all ten rounds.
// Ports: state, rk (round key), last (skip InvMixColumns) -> next_state.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    // InvShiftRows + InvSubBytes + AddRoundKey, bytes in column-major order
    logic [127:0] ark;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // row r rotates right by r: dst column c takes src column c-r
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            localparam int DST = 4 * c + r;
            assign ark[127-8*DST -: 8] =
                INV_SBOX[state[127-8*SRC -: 8]] ^ rk[127-8*DST -: 8];
        end

        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m0, m1, m2, m3;

        assign a0 = ark[127-32*c -: 8];
        assign a1 = ark[119-32*c -: 8];
        assign a2 = ark[111-32*c -: 8];
        assign a3 = ark[103-32*c -: 8];

        assign m0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                  ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        assign m1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                  ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        assign m2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                  ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        assign m3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                  ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);

        assign next_state[127-32*c -: 32] =
            last ? {a0, a1, a2, a3} : {m0, m1, m2, m3};
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: one round per clock, 10-cycle latency.
// Ports: clk, rst (sync, high), start, ct_in, key_in (round-10 key)
//        -> busy, done (1-cycle pulse), pt_out (held until next done).
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct_in,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt_out
);

    fsm_e         fsm;
    logic [3:0]   rnd;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [127:0] prk;
    logic [127:0] round_out;

    // Inverse key schedule: rk holds round rnd+1, prk is round rnd.
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] rot;
    logic [31:0] sub;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    assign n3 = w3 ^ w2;
    assign n2 = w2 ^ w1;
    assign n1 = w1 ^ w0;

    // first word of the earlier key depends on its own (recovered) last word
    assign rot = {n3[23:0], n3[31:24]};
    assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]],
                  SBOX[rot[15:8]],  SBOX[rot[7:0]]};
    assign n0  = w0 ^ sub ^ {RCON[rnd + 4'd1], 24'h0};

    assign prk = {n0, n1, n2, n3};

    aes_inv_round u_round (
        .state      (state_q),
        .rk         (prk),
        .last       (rnd == 4'd0),
        .next_state (round_out)
    );

    assign busy = (fsm == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= ST_IDLE;
            rnd     <= 4'd0;
            state_q <= '0;
            rk_q    <= '0;
            pt_out  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (fsm)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ct_in ^ key_in;
                        rk_q    <= key_in;
                        rnd     <= 4'd9;
                        fsm     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rnd != 4'd0) begin
                        state_q <= round_out;
                        rk_q    <= prk;
                        rnd     <= rnd - 4'd1;
                    end else begin
                        pt_out <= round_out;
                        done   <= 1'b1;
                        fsm    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed and randomized bench for aes_decrypt_core.
// Reference: independently derived S-box and a forward AES-128 model.
module tb_aes_decrypt_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] ct_in = '0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         done;
    logic [127:0] pt_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_core dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ct_in  (ct_in),
        .key_in (key_in),
        .busy   (busy),
        .done   (done),
        .pt_out (pt_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic encrypt(
        input  logic [127:0] key,
        input  logic [127:0] pt,
        output logic [127:0] ct,
        output logic [127:0] rk10
    );
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   t [16];
        logic [127:0] k;
        logic [127:0] p;
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        k = key;
        for (int i = 0; i < 4; i++) begin
            w[i] = k[127:96];
            k = k << 32;
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]],
                       sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        p = pt;
        for (int j = 0; j < 16; j++) begin
            st[j] = p[127:120];
            p = p << 8;
        end
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int j = 0; j < 16; j++) t[j] = sb[st[j]];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++)
                        st[4*c+q] = t[4*((c+q)%4)+q];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = st[4*c];
                        a1 = st[4*c+1];
                        a2 = st[4*c+2];
                        a3 = st[4*c+3];
                        st[4*c]   = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
                        st[4*c+1] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
                        st[4*c+2] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
                        st[4*c+3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
                    end
                end
            end
            for (int j = 0; j < 16; j++) begin
                tmp = w[4*r + j/4] << (8 * (j % 4));
                st[j] = st[j] ^ tmp[31:24];
            end
        end
        ct = '0;
        for (int j = 0; j < 16; j++) ct = {ct[119:0], st[j]};
        rk10 = {w[40], w[41], w[42], w[43]};
    endtask

    // Issues start at the current negedge; returns at the done negedge
    // (or after a 40-cycle bound, which shows up as lat != 10).
    task automatic run_block(
        input  logic [127:0] ct,
        input  logic [127:0] key,
        output logic [127:0] got,
        output int           lat,
        output int           busy_cycles,
        output bit           stable
    );
        logic [127:0] held;
        held = pt_out;
        stable = 1'b1;
        start = 1'b1;
        ct_in = ct;
        key_in = key;
        @(negedge clk);
        start = 1'b0;
        ct_in = {$urandom, $urandom, $urandom, $urandom};
        key_in = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (pt_out !== held) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        got = pt_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        ct_in = C1_CT;
        key_in = C1_KEY;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
        checks++;
        if (pt_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_pt got %h want 0", pt_out);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips_c1();
        logic [127:0] got;
        int lat, bc;
        bit stable;
        run_block(C1_CT, C1_KEY, got, lat, bc, stable);
        checks++;
        if (got !== C1_PT) begin
            errors++;
            $display("FAIL c1_pt got %h want %h", got, C1_PT);
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL c1_latency got %0d want 10", lat);
        end
        checks++;
        if (bc !== 10) begin
            errors++;
            $display("FAIL c1_busy_cycles got %0d want 10", bc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL c1_busy_at_done got %b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL c1_done_pulse got %b want 0", done);
        end
        checks++;
        if (pt_out !== C1_PT) begin
            errors++;
            $display("FAIL c1_pt_hold got %h want %h", pt_out, C1_PT);
        end
    endtask

    task automatic test_fips_b();
        logic [127:0] got;
        int lat, bc;
        bit stable;
        run_block(B_CT, B_KEY, got, lat, bc, stable);
        checks++;
        if (got !== B_PT) begin
            errors++;
            $display("FAIL b_pt got %h want %h", got, B_PT);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL b_pt_stable got %b want 1", stable);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] got1, got2;
        int lat1, lat2, bc;
        bit stable;
        run_block(C1_CT, C1_KEY, got1, lat1, bc, stable);
        run_block(B_CT, B_KEY, got2, lat2, bc, stable);
        checks++;
        if (got1 !== C1_PT) begin
            errors++;
            $display("FAIL b2b_first_pt got %h want %h", got1, C1_PT);
        end
        checks++;
        if (got2 !== B_PT) begin
            errors++;
            $display("FAIL b2b_second_pt got %h want %h", got2, B_PT);
        end
        checks++;
        if (lat2 + 1 !== 11) begin
            errors++;
            $display("FAIL b2b_gap got %0d want 11", lat2 + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        logic [127:0] got;
        int ndone, lat;
        start = 1'b1;
        ct_in = C1_CT;
        key_in = C1_KEY;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        lat = -1;
        got = '0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) begin
                ndone++;
                got = pt_out;
                if (lat < 0) lat = k;
            end
            if (k == 4) begin
                start = 1'b1;
                ct_in = 128'hdeadbeef_0badf00d_cafef00d_12345678;
                key_in = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
            end
            if (k == 5) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ign_done_count got %0d want 1", ndone);
        end
        checks++;
        if (got !== C1_PT) begin
            errors++;
            $display("FAIL ign_pt got %h want %h", got, C1_PT);
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL ign_latency got %0d want 10", lat);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] got;
        int lat, bc;
        bit stable;
        start = 1'b1;
        ct_in = B_CT;
        key_in = B_KEY;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_done got %b want 0", done);
        end
        checks++;
        if (pt_out !== 128'h0) begin
            errors++;
            $display("FAIL rst_mid_pt got %h want 0", pt_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy got %b want 0", busy);
        end
        rst = 1'b0;
        run_block(C1_CT, C1_KEY, got, lat, bc, stable);
        checks++;
        if (got !== C1_PT) begin
            errors++;
            $display("FAIL rst_rerun_pt got %h want %h", got, C1_PT);
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL rst_rerun_latency got %0d want 10", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [127:0] key, pt, ct, rk10, got;
        int lat, bc;
        bit stable;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            encrypt(key, pt, ct, rk10);
            run_block(ct, rk10, got, lat, bc, stable);
            checks++;
            if (got !== pt) begin
                errors++;
                $display("FAIL rand_pt n=%0d got %h want %h", n, got, pt);
            end
            checks++;
            if (stable !== 1'b1) begin
                errors++;
                $display("FAIL rand_stable n=%0d got %b want 1", n, stable);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
